// File: rtl/arith_pkg.sv
// Shared arithmetic-path definitions for the hack_n2t serial adder.
//   sa_state_t       : serial adder FSM state (IDLE -> RUN -> DONE -> IDLE)
//   SA_DEFAULT_WIDTH : default operand/result width
package arith_pkg;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_t;

  localparam int SA_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the bit slice of the serial adder.
// Ports:
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one operand bit pair per cycle through a single
// full_adder cell, LSB first, with a registered carry between bits.
//
// Handshakes (both sides): a transfer happens on a rising edge where the
// producer's valid and the consumer's ready are both 1. in_ready is 1 only in
// IDLE; out_valid is 1 only in DONE, and sum/cout/overflow are held stable
// there until out_ready is seen.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, cin sampled at acceptance)
//   out_valid/ out_ready: result handshake
//   sum, cout, overflow : a + b + cin mod 2^WIDTH, carry out of MSB,
//                         two's-complement overflow
//
// Optional feature (macro SERIAL_ADDER_SUB_EN): adds input sub; when 1 at
// acceptance the block computes a - b (B inverted, carry forced to 1).
module serial_adder
  import arith_pkg::*;
#(
  parameter int WIDTH = SA_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic op_sub;
  logic fa_s, fa_co;

`ifdef SERIAL_ADDER_SUB_EN
  assign op_sub = sub;
`else
  assign op_sub = 1'b0;
`endif

  full_adder u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      SA_IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          // Subtraction is a + ~b + 1; cin is ignored in that mode.
          b_sh_d  = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = SA_RUN;
        end
      end
      SA_RUN: begin
        // Sum bits enter at the MSB and walk down, so after WIDTH shifts
        // the first (LSB) result bit sits at sum[0].
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_co;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB.
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = SA_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SA_DONE: begin
        if (out_ready) state_d = SA_IDLE;
      end
      default: state_d = SA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SA_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == SA_IDLE);
  assign out_valid = (state_q == SA_DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder: directed cases plus randomized operations.
// Expected results come from an integer-arithmetic model and go into a queue;
// a monitor pops and compares whenever a result handshake occurs.
// Honours SERIAL_ADDER_SUB_EN the same way as the design.
module tb_serial_adder;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

`ifdef SERIAL_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Packed expectation: {cout, overflow, sum}
  logic [W+1:0] exp_q[$];
  logic [W+1:0] mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Unsigned sum gives result and carry-out; signed sum range gives overflow.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c, input logic s);
    logic [W-1:0] yy;
    logic         cc;
    longint       full;
    longint       sres;
    logic         ovf;
    logic [W:0]   fv;
    yy   = s ? ~y : y;
    cc   = s ? 1'b1 : c;
    full = longint'(x) + longint'(yy) + longint'(cc);
    sres = longint'($signed(x)) + longint'($signed(yy)) + longint'(cc);
    ovf  = (sres > (longint'(1) <<< (W - 1)) - 1) || (sres < -(longint'(1) <<< (W - 1)));
    fv   = full[W:0];
    return {fv[W], ovf, fv[W-1:0]};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got sum 0x%0h expected no result", sum);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sum", 32'(sum), 32'(mon_e[W-1:0]));
        chk("cout", 32'(cout), 32'(mon_e[W+1]));
        chk("overflow", 32'(overflow), 32'(mon_e[W]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_in_ready();
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  task automatic accept(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic ci, input logic si);
    wait_in_ready();
    a = ai; b = bi; cin = ci; sub = si;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Scramble inputs: the DUT must not sample them after acceptance.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic do_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                       input logic ci, input logic si, input int hold);
    int n;
    logic [W-1:0] snap;
    logic         s_eff;
    s_eff = si & HAS_SUB;
    accept(ai, bi, ci, si);
    exp_q.push_back(model(ai, bi, ci, s_eff));
    n = 0;
    while (!out_valid && n < W + 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'(W));
    snap = sum;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'(snap));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_out_valid", 32'(out_valid), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'd0);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_outputs("reset");

    // Directed cases
    do_op(16'h0001, 16'hFFFF, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h00FF, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 5);   // backpressure for 5 cycles
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 0);

    // Abort during RUN: counter reaches 7 seven edges after acceptance
    accept(16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
    repeat (7) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("abort");
    repeat (W + 2) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'(out_valid), 32'd0);
    end
    do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

`ifdef SERIAL_ADDER_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);
`endif

    // Randomized operations
    for (int k = 0; k < 40; k++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));
    end

    @(posedge clk); #1;
    chk("leftover_expectations", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial WIDTH-bit adder for the hack_n2t arithmetic/logic path.
- It is the sequential stage wrapped around the 1-bit full adder cell. Each cycle it feeds one operand bit pair plus the registered carry into the cell, and shifts the resulting sum bit into a result register.
- It gives the ALU a small-area add option, with valid/ready handshakes on both input and output.

Parameters:
- WIDTH, 16, operand and result width in bits; legal range is 2 or more.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream is offering operands.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in for the operation.
- out_valid  output  1  result is available.
- out_ready  input  1  downstream is accepting the result.
- sum  output  WIDTH  result, a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- overflow  output  1  two's-complement overflow, defined as carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: one clock and one reset, both as named above. Reset is synchronous and active-high.
  - Reset is sampled at the rising edge of clk; it is not asynchronous.
  - Reset gives state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, bit counter=0, carry register=0.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On an edge with in_valid=1: latch a and b into shift registers, load the carry register with cin, clear the counter and sum, and go to RUN.
- State RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, the full-adder cell computes a_sh[0] + b_sh[0] + carry.
  - The sum bit shifts into sum from the MSB side (LSB-first fill). a_sh and b_sh shift right, the carry register takes the cell's carry output, and the counter increments.
  - On the last bit (counter==WIDTH-1):
    - The carry register value feeding the cell is the carry into the MSB.
    - overflow = that value XOR cell carry.
    - cout = cell carry.
    - Go to DONE.
- State DONE:
  - out_valid=1; sum, cout and overflow are stable.
  - If out_ready=1, go to IDLE. Otherwise hold all outputs indefinitely.
  - in_ready=0 in DONE, so there is one bubble cycle between operations.
- Latency: if operands are accepted at edge N, out_valid is 1 from edge N+WIDTH onward. Throughput is one result per WIDTH+2 cycles with no backpressure.
- Input operands are not sampled after acceptance; a, b and cin may change freely during RUN and DONE.
- sum contents during RUN are undefined to consumers; they are meaningful only while out_valid=1.
- Reset during RUN or DONE aborts the operation. The next cycle is IDLE with the reset values above; no partial result is presented.
- Counter width is $clog2(WIDTH). The counter never wraps within an operation.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - An extra input port sub (1 bit) exists and is sampled at acceptance.
  - sub=1: operand B is latched inverted and the carry register is loaded with 1, ignoring cin. The block computes a - b.
  - cout=1 means no borrow. overflow is the signed-subtract overflow, using the same XOR rule.
  - sub=0: plain add.
- Undefined: the sub port is absent and behaviour is add-only.

Decomposition:
- Package arith_pkg holds:
  - the state enum sa_state_t {SA_IDLE, SA_RUN, SA_DONE};
  - the constant SA_DEFAULT_WIDTH=16.
- Sub-module: one full_adder instance is the bit slice.
- Shift registers, counter and FSM stay inline in serial_adder.

Test Plan:
- a=0x0001, b=0xFFFF, cin=0:
  - sum=0x0000, cout=1, overflow=0;
  - out_valid rises exactly 16 cycles after the accept edge.
- a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, overflow=1.
- a=0x00FF, b=0x0000, cin=1 → sum=0x0100, cout=0, overflow=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE.
  - out_valid and sum stay constant; in_ready stays 0.
  - Raising out_ready gives IDLE next cycle, with in_ready=1.
- Reset asserted for one cycle when counter==7 in RUN:
  - next cycle is IDLE with all outputs 0;
  - a following op a=0x1234, b=0x1111 gives sum=0x2345.
- SERIAL_ADDER_SUB_EN defined:
  - sub=1, a=0x0005, b=0x0007 → sum=0xFFFE, cout=0, overflow=0;
  - sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, overflow=1.
